// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start duty sequencer for a PWM generator. It accepts a target duty over valid/ready
// and ramps the applied duty toward it in fixed steps, changing duty only on period boundaries.
module pwm_duty_ramp_ctrl #(
    parameter int DUTY_W       = 4,
    parameter int PERIOD       = 16,
    parameter int STEP_PERIODS = 2,
    parameter int STEP         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              period_start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int PC_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PERIOD - 1);
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(STEP_PERIODS - 1);
    localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W + 1)'(STEP);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Handshake: a target is transferred on any rising edge where tgt_valid && tgt_ready;
    // tgt_ready depends only on state, never on tgt_valid, so the offer may be held freely.
    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic              done_q, done_d;

    logic              accept;
    logic              period_end;
    logic              step_evt;
    logic [DUTY_W:0]   duty_x, tgt_x, up_sum, dn_diff, dn_floor;
    logic [DUTY_W-1:0] duty_step;

    assign accept     = tgt_valid && tgt_ready;
    assign period_end = enable && (pcnt_q == PC_LAST);
    assign step_evt   = period_end && (scnt_q == SC_LAST);

    // Widened arithmetic so a step past either end clamps to the target instead of wrapping.
    always_comb begin
        duty_x   = {1'b0, duty_q};
        tgt_x    = {1'b0, target_q};
        up_sum   = duty_x + STEP_X;
        dn_diff  = duty_x - STEP_X;
        dn_floor = tgt_x + STEP_X;
        duty_step = target_q;
        if (duty_q < target_q) begin
            duty_step = (up_sum >= tgt_x) ? target_q : up_sum[DUTY_W-1:0];
        end else if (duty_q > target_q) begin
            duty_step = (duty_x >= dn_floor) ? dn_diff[DUTY_W-1:0] : target_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF:   state_d = (target_d != '0) ? S_RAMP : S_HOLD;
                S_RAMP:  if (step_evt && (duty_step == target_q)) state_d = S_HOLD;
                S_HOLD:  if (accept && (tgt_duty != duty_q)) state_d = S_RAMP;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        tgt_ready    = (state_q != S_RAMP);
        busy         = (state_q == S_RAMP);
        period_start = enable && (pcnt_q == '0);
        duty         = duty_q;
        done         = done_q;
        state_dbg    = state_q;
    end

    // Datapath next-state; enable=0 wins over steps and acceptance but the target still latches.
    always_comb begin
        target_d = accept ? tgt_duty : target_q;

        pcnt_d = pcnt_q;
        if (!enable) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = (pcnt_q == PC_LAST) ? '0 : pcnt_q + 1'b1;
        end

        scnt_d = scnt_q;
        if (!enable || accept) begin
            scnt_d = '0;
        end else if (period_end) begin
            scnt_d = (scnt_q == SC_LAST) ? '0 : scnt_q + 1'b1;
        end

        duty_d = duty_q;
        if (!enable || (state_q == S_OFF)) begin
            duty_d = '0;
        end else if ((state_q == S_RAMP) && step_evt) begin
            duty_d = duty_step;
        end

        done_d = 1'b0;
        if (enable) begin
            if ((state_q == S_RAMP) && step_evt && (duty_step == target_q)) begin
                done_d = 1'b1;
            end else if ((state_q == S_HOLD) && accept && (tgt_duty == duty_q)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q   <= '0;
            target_q <= '0;
            pcnt_q   <= '0;
            scnt_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            pcnt_q   <= pcnt_d;
            scnt_q   <= scnt_d;
            done_q   <= done_d;
        end
    end

endmodule
